mem_responder: RTL
==================

# mem_responder

Word-addressed memory responder serving the multicycle CPU's fetch, load and store traffic over a single-outstanding req/ack handshake. The control FSM drives requests (instruction fetch in IF, lw/sw in MEM); this block is the memory-side end of that interface. It accepts one request, inserts a programmable number of wait states, performs the read or write, and returns a one-cycle acknowledge. It replaces the zero-latency combinational memory model, so CPU control can be verified against realistic latency.

## Interface
- ADDR_W, 10, word-address bits; depth = 2^ADDR_W 32-bit words
- WAIT_CYCLES, 2, extra wait-state cycles per access (0..255)
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  request valid, sampled only in IDLE
- we  in  1  1 = write, 0 = read; latched with req
- addr  in  32  byte address; latched with req
- wdata  in  32  write data; latched with req
- byte_en  in  4  byte write mask; present only with MEM_RESP_BYTE_MASK_EN
- rdata  out  32  read data, registered
- ack  out  1  transaction-complete pulse, one cycle
- err  out  1  misaligned-access flag, valid only while ack=1
- busy  out  1  high from acceptance until ack cycle inclusive

## Operation
- States: IDLE, WAIT, ACK; 8-bit down-counter cnt.
- IDLE: on req=1, latch we/addr/wdata (and byte_en), set busy, go WAIT with cnt=WAIT_CYCLES. Otherwise remain.
- WAIT: if cnt!=0, decrement. If cnt==0, perform the access on this edge and go ACK.
- Access: word index = latched addr[ADDR_W+1:2]; addr bits above ADDR_W+1 ignored (aliases wrap). Read loads rdata; write updates array, rdata unchanged.
- Misaligned (latched addr[1:0]!=0): no array access, rdata unchanged, err=1 in ACK.
- ACK: ack=1 for exactly one cycle, then IDLE. req in ACK is ignored; if req is still high in the following IDLE cycle, it is a new request.
- Inputs after acceptance are ignored until the next IDLE.
- Reset values: state IDLE, cnt 0, ack 0, err 0, busy 0, rdata 0. Array contents are not reset.
- Reset mid-transaction: abort to IDLE. A write not yet committed (reset before the WAIT→ACK edge) is dropped. No ack is issued.

## Timing
- Edge E0 accepts req. The access commits at edge E0+WAIT_CYCLES+1. ack, err and the new rdata are visible in the cycle after that edge.
- Request-to-ack latency is WAIT_CYCLES+2 edges.
- Minimum spacing between accepted requests is WAIT_CYCLES+3 cycles.
- rdata holds its value from the read ack until the next read commits.
- busy rises the cycle after E0 and falls the cycle after ack.

## Configuration
- MEM_RESP_BYTE_MASK_EN defined:
  - byte_en port exists.
  - A write updates only lanes with byte_en[i]=1 (lane i = bits 8i+7:8i).
  - byte_en=0 completes with ack and leaves memory unchanged.
- MEM_RESP_BYTE_MASK_EN undefined:
  - No byte_en port.
  - Every write replaces the full word.

## Test plan
- Reset, then idle with req=0 for 10 cycles -> ack, err and busy stay 0; rdata=0.
- WAIT_CYCLES=2: write 0xDEADBEEF to 0x10, then read 0x10 -> each ack arrives exactly 4 edges after acceptance; read returns rdata=0xDEADBEEF.
- Hold req high continuously with reads of 0x0 and 0x4 -> one ack every 5 cycles (WAIT_CYCLES+3); the req held high during ACK creates no extra transaction.
- Write to 0x13 -> ack=1 with err=1; reading word 0x10 shows the prior contents unchanged.
- Write 0x12345678 to 0x20, then assert rst_n=0 one cycle after acceptance; after reset, read 0x20 -> old value returned; no ack seen for the aborted write.
- With MEM_RESP_BYTE_MASK_EN: word holds 0xFFFFFFFF; write 0x00000000 with byte_en=4'b0101 -> read returns 0xFF00FF00.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory end of a single-outstanding req/ack CPU bus.
// Latency: access commits WAIT_CYCLES+1 edges after acceptance; ack is visible the cycle after that.
// Backpressure: one transaction at a time; req is only sampled in IDLE, busy covers the rest.
// Optional feature: define MEM_RESP_BYTE_MASK_EN to add the byte_en write-lane mask.
module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef MEM_RESP_BYTE_MASK_EN
  input  logic [3:0]  byte_en,
`endif
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;
  logic                err_q;
  logic                accept, commit;
  logic                misaligned;
  logic [ADDR_W-1:0]   widx;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // Address bits above the word index alias onto the same words.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  assign misaligned = (addr_q[1:0] != 2'b00);
  assign widx       = addr_q[ADDR_W+1:2];

  // Next-state logic: count down wait states, commit on the last WAIT cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = WAIT;
          cnt_d   = 8'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          commit  = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, request capture, read data and error flag; reset aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      err_q   <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr[ADDR_W+1:0];
        wdata_q <= wdata;
`ifdef MEM_RESP_BYTE_MASK_EN
        be_q    <= byte_en;
`else
        be_q    <= 4'hF;
`endif
      end
      if (commit) begin
        err_q <= misaligned;
        if (!we_q && !misaligned) rdata <= mem[widx];
      end
    end
  end

  // Array write on the commit edge; only enabled lanes change.
  always_ff @(posedge clk) begin
    if (commit && we_q && !misaligned) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[widx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign ack  = (state_q == ACK);
  assign err  = ack & err_q;
  assign busy = (state_q != IDLE);

endmodule
